// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline stage.
//   Registers the MEM->WB bus, extracts and sign/zero-extends load data from the
//   synchronous data SRAM read, and drives the register-file write port, the WB->ID
//   forwarding bus and the retirement debug trace.
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   stall, flush         hold / discard the instruction in WB (flush wins)
//   mem_to_wb_valid/bus  incoming instruction {pc, rf_we, rf_waddr, result, load_op, addr_lo}
//   data_sram_rdata      SRAM read data, valid only in the load's first cycle in WB
//   wb_to_rf_bus         {we, waddr, wdata} register-file write port (commit only)
//   wb_to_id_bus         {we, waddr, wdata} forwarding bus (asserted while valid)
//   debug_wb_*           retirement trace
module wb_stage #(
    parameter int MEM_TO_WB_WD = 75,
    parameter int WB_TO_RF_WD  = 38
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    mem_to_wb_valid,
    input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
    output logic [WB_TO_RF_WD-1:0]  wb_to_id_bus,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_wen,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata
);

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LW  = 3'b101;

    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_result;
    logic [2:0]  wb_load_op;
    logic [1:0]  wb_addr_lo;
    logic        hold_valid;
    logic [31:0] hold_data;

    logic        is_load;
    logic [31:0] ld_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] wdata;
    logic        commit;
    logic        id_we;
    logic        rf_we;

    assign is_load = (wb_load_op >= LD_LB) && (wb_load_op <= LD_LW);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid    <= 1'b0;
            wb_pc       <= '0;
            wb_rf_we    <= 1'b0;
            wb_rf_waddr <= '0;
            wb_result   <= '0;
            wb_load_op  <= '0;
            wb_addr_lo  <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
        end else if (flush) begin
            wb_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= mem_to_wb_valid;
            wb_pc       <= mem_to_wb_bus[74:43];
            wb_rf_we    <= mem_to_wb_bus[42];
            wb_rf_waddr <= mem_to_wb_bus[41:37];
            wb_result   <= mem_to_wb_bus[36:5];
            wb_load_op  <= mem_to_wb_bus[4:2];
            wb_addr_lo  <= mem_to_wb_bus[1:0];
            hold_valid  <= 1'b0;
        end else if (wb_valid && is_load && !hold_valid) begin
            // SRAM rdata is only valid in the first WB cycle; capture it so a
            // stall of any length still commits the original load data.
            hold_valid <= 1'b1;
            hold_data  <= data_sram_rdata;
        end
    end

    assign ld_src  = hold_valid ? hold_data : data_sram_rdata;
    assign ld_byte = ld_src[8*wb_addr_lo +: 8];
    assign ld_half = wb_addr_lo[1] ? ld_src[31:16] : ld_src[15:0];

    always_comb begin
        ld_ext = ld_src;
        case (wb_load_op)
            LD_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_ext = {24'h0, ld_byte};
            LD_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_ext = {16'h0, ld_half};
            default: ld_ext = ld_src;
        endcase
    end

    assign wdata  = is_load ? ld_ext : wb_result;
    assign commit = wb_valid && !stall && !flush;
    // r0 writes are suppressed on both buses so neither RF nor ID ever sees them.
    assign id_we  = wb_valid && wb_rf_we && (wb_rf_waddr != 5'd0);
    assign rf_we  = commit && id_we;

    assign wb_to_rf_bus      = {rf_we, wb_rf_waddr, wdata};
    assign wb_to_id_bus      = {id_we, wb_rf_waddr, wdata};
    assign debug_wb_pc       = wb_valid ? wb_pc : 32'h0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = commit ? wb_rf_waddr : 5'd0;
    assign debug_wb_rf_wdata = commit ? wdata : 32'h0;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        flush;
    logic        mem_to_wb_valid;
    logic [74:0] mem_to_wb_bus;
    logic [31:0] data_sram_rdata;
    logic [37:0] wb_to_rf_bus;
    logic [37:0] wb_to_id_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int vectors;
    int miscompares;

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .stall             (stall),
        .flush             (flush),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .data_sram_rdata   (data_sram_rdata),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .wb_to_id_bus      (wb_to_id_bus),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently in WB and the load word it owns.
    bit          m_valid;
    logic [31:0] m_pc;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_result;
    logic [2:0]  m_lop;
    logic [1:0]  m_alo;
    bit          m_have_word;
    logic [31:0] m_word;

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_we = 0; m_waddr = 0; m_result = 0;
        m_lop = 0; m_alo = 0; m_have_word = 0; m_word = 0;
    endtask

    function automatic bit m_is_load();
        return (m_lop >= 3'd1) && (m_lop <= 3'd5);
    endfunction

    function automatic logic [31:0] exp_wdata();
        logic [31:0] w;
        int unsigned b, h;
        w = m_have_word ? m_word : data_sram_rdata;
        b = (w >> (8 * m_alo)) & 32'hFF;
        h = (w >> (16 * m_alo[1])) & 32'hFFFF;
        case (m_lop)
            3'd1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd2: return b;
            3'd3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4: return h;
            3'd5: return w;
            default: return m_result;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit commit, id_we, rf_we;
        logic [31:0] wd;
        commit = m_valid && !stall && !flush;
        id_we  = m_valid && m_we && (m_waddr != 0);
        rf_we  = commit && id_we;
        wd     = exp_wdata();
        chk("rf_bus",    64'(wb_to_rf_bus),      64'({rf_we, m_waddr, wd}));
        chk("id_bus",    64'(wb_to_id_bus),      64'({id_we, m_waddr, wd}));
        chk("dbg_pc",    64'(debug_wb_pc),       64'(m_valid ? m_pc : 32'h0));
        chk("dbg_wen",   64'(debug_wb_rf_wen),   64'(rf_we ? 4'hF : 4'h0));
        chk("dbg_wnum",  64'(debug_wb_rf_wnum),  64'(commit ? m_waddr : 5'd0));
        chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(commit ? wd : 32'h0));
    endtask

    task automatic model_edge();
        if (!resetn) begin
            model_reset();
        end else if (flush) begin
            m_valid = 0; m_have_word = 0;
        end else if (!stall) begin
            m_valid  = mem_to_wb_valid;
            m_pc     = mem_to_wb_bus[74:43];
            m_we     = mem_to_wb_bus[42];
            m_waddr  = mem_to_wb_bus[41:37];
            m_result = mem_to_wb_bus[36:5];
            m_lop    = mem_to_wb_bus[4:2];
            m_alo    = mem_to_wb_bus[1:0];
            m_have_word = 0;
        end else if (m_valid && m_is_load() && !m_have_word) begin
            // a stalled load keeps the word it saw in its first WB cycle
            m_have_word = 1;
            m_word = data_sram_rdata;
        end
    endtask

    // One cycle: clock edge (model follows), then drive new inputs and check outputs.
    task automatic step(input bit mv, input logic [31:0] pc, input bit we, input logic [4:0] wa,
                        input logic [31:0] res, input logic [2:0] lop, input logic [1:0] alo,
                        input bit st, input bit fl, input logic [31:0] rd);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        mem_to_wb_valid = mv;
        mem_to_wb_bus   = {pc, we, wa, res, lop, alo};
        stall           = st;
        flush           = fl;
        data_sram_rdata = rd;
        #1;
        check_model();
    endtask

    task automatic idle(input bit st, input logic [31:0] rd);
        step(0, 32'h0, 0, 5'd0, 32'h0, 3'd0, 2'd0, st, 0, rd);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        resetn = 1'b0;
        stall = 0; flush = 0; mem_to_wb_valid = 0; mem_to_wb_bus = '0; data_sram_rdata = 32'h1111_2222;

        idle(0, 32'h1111_2222);
        chk("reset_rf_bus", 64'(wb_to_rf_bus), 64'h0);
        chk("reset_pc", 64'(debug_wb_pc), 64'h0);
        resetn = 1'b1;

        // ALU op
        step(1, 32'hBFC0_0000, 1, 5'd5, 32'h1234, 3'd0, 2'd0, 0, 0, 32'h0);
        idle(0, 32'h0);
        chk("alu_rf_bus", 64'(wb_to_rf_bus), 64'({1'b1, 5'd5, 32'h1234}));
        chk("alu_wen", 64'(debug_wb_rf_wen), 64'h0F);

        // load extension
        step(1, 32'h100, 1, 5'd1, 32'h0, 3'd1, 2'd3, 0, 0, 32'h0);
        step(1, 32'h104, 1, 5'd2, 32'h0, 3'd2, 2'd3, 0, 0, 32'h80FF_0000);
        chk("lb", 64'(wb_to_rf_bus[31:0]), 64'hFFFF_FF80);
        step(1, 32'h108, 1, 5'd3, 32'h0, 3'd3, 2'd2, 0, 0, 32'h80FF_0000);
        chk("lbu", 64'(wb_to_rf_bus[31:0]), 64'h80);
        step(1, 32'h10C, 1, 5'd4, 32'h0, 3'd4, 2'd0, 0, 0, 32'h80FF_0000);
        chk("lh", 64'(wb_to_rf_bus[31:0]), 64'hFFFF_80FF);
        idle(0, 32'h80FF_0000);
        chk("lhu", 64'(wb_to_rf_bus[31:0]), 64'h0);

        // lw held across a 3-cycle stall
        step(1, 32'h200, 1, 5'd7, 32'h0, 3'd5, 2'd0, 0, 0, 32'h0);
        step(1, 32'h300, 1, 5'd8, 32'h99, 3'd0, 2'd0, 1, 0, 32'hDEAD_BEEF);
        chk("stall1_id_we", 64'(wb_to_id_bus[37]), 64'h1);
        chk("stall1_rf_we", 64'(wb_to_rf_bus[37]), 64'h0);
        step(1, 32'h300, 1, 5'd8, 32'h99, 3'd0, 2'd0, 1, 0, 32'h1234_5678);
        chk("stall2_wdata", 64'(wb_to_id_bus[31:0]), 64'hDEAD_BEEF);
        chk("stall2_id_we", 64'(wb_to_id_bus[37]), 64'h1);
        step(1, 32'h300, 1, 5'd8, 32'h99, 3'd0, 2'd0, 1, 0, 32'h0BAD_F00D);
        chk("stall3_rf_we", 64'(wb_to_rf_bus[37]), 64'h0);
        idle(0, 32'h0);
        chk("release_rf_bus", 64'(wb_to_rf_bus), 64'({1'b1, 5'd7, 32'hDEAD_BEEF}));
        idle(0, 32'h0);
        chk("after_release_we", 64'(wb_to_rf_bus[37]), 64'h0);

        // stall + flush on a valid load
        step(1, 32'h220, 1, 5'd9, 32'h0, 3'd5, 2'd0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 1, 1, 32'hAAAA_5555);
        chk("flush_rf_we", 64'(wb_to_rf_bus[37]), 64'h0);
        idle(0, 32'h1357_9BDF);
        chk("flush_pc", 64'(debug_wb_pc), 64'h0);
        chk("flush_id_we", 64'(wb_to_id_bus[37]), 64'h0);
        chk("flush_no_hold", 64'(wb_to_id_bus[31:0]), 64'h1357_9BDF);

        // write to r0
        step(1, 32'h1000, 1, 5'd0, 32'h55, 3'd0, 2'd0, 0, 0, 32'h0);
        idle(0, 32'h0);
        chk("r0_rf_we", 64'(wb_to_rf_bus[37]), 64'h0);
        chk("r0_id_we", 64'(wb_to_id_bus[37]), 64'h0);
        chk("r0_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("r0_pc", 64'(debug_wb_pc), 64'h1000);

        // reset in the middle of a stall
        step(1, 32'h400, 1, 5'd3, 32'h0, 3'd5, 2'd0, 0, 0, 32'h0);
        idle(1, 32'hCAFE_F00D);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_rf_bus", 64'(wb_to_rf_bus), 64'h0);
        chk("rst_id_bus", 64'(wb_to_id_bus), 64'h0);
        chk("rst_pc", 64'(debug_wb_pc), 64'h0);
        chk("rst_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("rst_wnum", 64'(debug_wb_rf_wnum), 64'h0);
        chk("rst_wdata", 64'(debug_wb_rf_wdata), 64'h0);
        model_reset();
        idle(1, 32'hCAFE_F00D);
        resetn = 1'b1;
        step(1, 32'h500, 1, 5'd4, 32'h77, 3'd0, 2'd0, 0, 0, 32'h0);
        idle(0, 32'h0);
        chk("post_rst_rf_bus", 64'(wb_to_rf_bus), 64'({1'b1, 5'd4, 32'h77}));
        chk("post_rst_pc", 64'(debug_wb_pc), 64'h500);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0] lop;
            logic [1:0] alo;
            lop = 3'($urandom_range(0, 7));
            alo = 2'($urandom_range(0, 3));
            if (lop == 3'd3 || lop == 3'd4) alo = alo & 2'b10;
            if (lop == 3'd5) alo = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 5'($urandom_range(0, 31)),
                 $urandom, lop, alo, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
